// File: rtl/fifo_ctrl_param.sv
// Parametrised FIFO pointer/flag controller driving an external dual-port RAM.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl_param #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  output logic              wr_en,
  output logic              rd_en,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [ADDR_W-1:0] readAddr
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;

  // Flags come only from the registered count, so they lag acceptance by one edge.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);

  // A full FIFO still accepts a push when a pop happens in the same cycle.
  assign rd_en = read & ~empty;
  assign wr_en = write & (~full | read);

  assign count     = count_q;
  assign writeAddr = wrPtr_q;
  assign readAddr  = rdPtr_q;

  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (wr_en) wrPtr_d = wrPtr_q + ADDR_W'(1);
    if (rd_en) rdPtr_d = rdPtr_q + ADDR_W'(1);
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Rejected requests latch until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (write & ~wr_en);
      underflow_q <= underflow_q | (read & ~rd_en);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param (ADDR_W=2): directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue-based model.
module tb_fifo_ctrl_param;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic read = 1'b0;
  logic write = 1'b0;
  logic wr_en, rd_en, empty, full, almost_empty, almost_full;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] writeAddr, readAddr;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  fifo_ctrl_param #(.ADDR_W(ADDR_W), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .write(write),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .empty(empty),
    .full(full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .count(count),
    .writeAddr(writeAddr),
    .readAddr(readAddr)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue holding the RAM address of every stored entry, oldest first.
  int  mQ[$];
  int  mWrTotal = 0;
  int  mRdTotal = 0;
  bit  mValid = 1'b0;
  bit  mOvf = 1'b0;
  bit  mUnf = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mQ.delete();
        mWrTotal = 0;
        mRdTotal = 0;
        mOvf = 1'b0;
        mUnf = 1'b0;
        mValid = 1'b1;
      end else if (mValid) begin
        bit acceptRd, acceptWr;
        acceptRd = read && (mQ.size() > 0);
        acceptWr = write && ((mQ.size() < DEPTH) || read);
        if (write && !acceptWr) mOvf = 1'b1;
        if (read && !acceptRd) mUnf = 1'b1;
        if (acceptRd) begin
          void'(mQ.pop_front());
          mRdTotal++;
        end
        if (acceptWr) begin
          mQ.push_back(mWrTotal % DEPTH);
          mWrTotal++;
        end
      end
    end
  end

  // Every cycle, mid-period: compare all DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mValid) begin
        int n;
        n = mQ.size();
        checkOutput("m_count", 32'(count), 32'(n));
        checkOutput("m_empty", 32'(empty), 32'(n == 0));
        checkOutput("m_full", 32'(full), 32'(n == DEPTH));
        checkOutput("m_almost_empty", 32'(almost_empty), 32'(n <= AE));
        checkOutput("m_almost_full", 32'(almost_full), 32'(n >= AF));
        checkOutput("m_writeAddr", 32'(writeAddr), 32'(mWrTotal % DEPTH));
        checkOutput("m_readAddr", 32'(readAddr), 32'((n > 0) ? mQ[0] : (mRdTotal % DEPTH)));
        if (!reset) begin
          checkOutput("m_rd_en", 32'(rd_en), 32'(read && (n > 0)));
          checkOutput("m_wr_en", 32'(wr_en), 32'(write && ((n < DEPTH) || read)));
        end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        checkOutput("m_overflow", 32'(overflow), 32'(mOvf));
        checkOutput("m_underflow", 32'(underflow), 32'(mUnf));
`endif
      end
    end
  end

  // Drive inputs for one cycle and return mid-period, before the edge that samples them.
  task automatic applyStimulus(input logic r, input logic w, input logic rst);
    read  = r;
    write = w;
    reset = rst;
    @(negedge clk);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset then idle.
    applyStimulus(1'b0, 1'b0, 1'b1); stepCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0); stepCycle();
    end
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_addrs", {writeAddr, readAddr}, 32'd0);
    checkOutput("rst_strobes", {wr_en, rd_en}, 32'd0);

    // Fill to full.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("fill_wr_en", 32'(wr_en), 32'd1);
      stepCycle();
      checkOutput("fill_count", 32'(count), 32'(i));
      checkOutput("fill_almost_full", 32'(almost_full), 32'(i >= 3));
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_wrap_writeAddr", 32'(writeAddr), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fifth_write_wr_en", 32'(wr_en), 32'd0);
    stepCycle();
    checkOutput("fifth_write_count", 32'(count), 32'd4);

    // Full-bypass: simultaneous read and write while full.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("bypass_strobes", {wr_en, rd_en}, 32'd3);
      stepCycle();
      checkOutput("bypass_count", 32'(count), 32'd4);
    end
    checkOutput("bypass_readAddr", 32'(readAddr), 32'd3);
    checkOutput("bypass_writeAddr", 32'(writeAddr), 32'd3);

    // Empty with read and write: only the write is accepted.
    applyStimulus(1'b0, 1'b0, 1'b1); stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("empty_rw_strobes", {wr_en, rd_en}, 32'd2);
    stepCycle();
    checkOutput("empty_rw_count", 32'(count), 32'd1);
    checkOutput("empty_rw_readAddr", 32'(readAddr), 32'd0);
    checkOutput("empty_rw_writeAddr", 32'(writeAddr), 32'd1);

    // Reset mid-stream overrides a pending write.
    applyStimulus(1'b0, 1'b0, 1'b1); stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1); stepCycle();
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_writeAddr", 32'(writeAddr), 32'd0);

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    applyStimulus(1'b1, 1'b0, 1'b0); stepCycle();
    checkOutput("underflow_set", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("underflow_sticky", 32'(underflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0); stepCycle();
    end
    checkOutput("overflow_clear_before", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0); stepCycle();
    checkOutput("overflow_set", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1); stepCycle();
    checkOutput("errflags_reset", {overflow, underflow}, 32'd0);
`endif

    // Randomized traffic with occasional resets; the compare process does the checking.
    for (int i = 0; i < 2000; i++) begin
      logic r, w, rst;
      r   = ($urandom_range(0, 99) < 45);
      w   = ($urandom_range(0, 99) < 55);
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(r, w, rst);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0); stepCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
